// File: rtl/dsp_p_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_p_serializer
// Purpose  : Captures a WIDTH-bit P result and unloads it as NW slices of
//            OUT_W bits, LSB slice first, over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module dsp_p_serializer #(
  parameter int WIDTH = 48,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CLK_EN,
  input  logic [WIDTH-1:0] P,
  input  logic             p_valid,
  input  logic             clr_ovr,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             overrun
);

  localparam int NW = WIDTH / OUT_W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] c_idx_last = IW'(NW - 1);

  generate
    if ((OUT_W < 1) || (WIDTH < OUT_W) || ((WIDTH % OUT_W) != 0)) begin : g_bad_width
      $error("dsp_p_serializer: WIDTH must be a positive multiple of OUT_W");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             r_ovr;
  logic             w_ovr_nxt;

  logic             w_busy;
  logic             w_last;
  logic             w_hs;
  logic             w_drop;
  logic [OUT_W-1:0] w_dout;

  assign w_busy = (r_state == SEND);
  assign w_last = w_busy && (r_idx == c_idx_last);
  assign w_hs   = w_busy && dout_ready && CLK_EN;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
      r_ovr   <= 1'b0;
    end else if (CLK_EN) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // A new P is only taken when the unit is idle or the final slice is leaving
  // in the same cycle; any other p_valid while sending is a dropped result.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (p_valid) begin
          w_hold_nxt  = P;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs && w_last) begin
          w_idx_nxt = '0;
          if (p_valid) begin
            w_hold_nxt = P;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_hs) begin
            w_idx_nxt = r_idx + IW'(1);
          end
          w_drop = p_valid;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_ovr_nxt = r_ovr;
    if (w_drop) begin
      w_ovr_nxt = 1'b1;
    end else if (clr_ovr) begin
      w_ovr_nxt = 1'b0;
    end
  end

  always_comb begin
    w_dout = '0;
    for (int i = 0; i < NW; i++) begin
      if (r_idx == IW'(i)) begin
        w_dout = r_hold[i*OUT_W +: OUT_W];
      end
    end
  end

  assign dout       = w_dout;
  assign dout_valid = w_busy;
  assign dout_last  = w_last;
  assign busy       = w_busy;
  assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_dsp_p_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_p_serializer
// Purpose  : Scoreboard bench for dsp_p_serializer with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_p_serializer;

  localparam int WIDTH = 48;
  localparam int OUT_W = 16;

  logic             clk;
  logic             rst;
  logic             CLK_EN;
  logic [WIDTH-1:0] P;
  logic             p_valid;
  logic             clr_ovr;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  logic [OUT_W:0] exp_q[$];

  dsp_p_serializer #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .CLK_EN     (CLK_EN),
    .P          (P),
    .p_valid    (p_valid),
    .clr_ovr    (clr_ovr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected slices of a word, low slice first; the top slice carries last=1.
  task automatic push_word(input logic [WIDTH-1:0] w);
    exp_q.push_back({1'b0, w[15:0]});
    exp_q.push_back({1'b0, w[31:16]});
    exp_q.push_back({1'b1, w[47:32]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [WIDTH-1:0] w);
    P       = w;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
  endtask

  // Monitor: every handshake about to be taken is checked against the queue.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready && CLK_EN) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slice: got last=%0b dout=0x%0h expected none at %0t",
                 dout_last, dout, $time);
      end else begin
        chk("slice", {47'd0, dout_last, dout}, {47'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    CLK_EN     = 1'b1;
    P          = '0;
    p_valid    = 1'b0;
    clr_ovr    = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_valid", 64'(dout_valid), 64'h0);
    chk("rst_last", 64'(dout_last), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ovr", 64'(overrun), 64'h0);

    // Basic unload with ready held high
    dout_ready = 1'b1;
    push_word(48'h1234_5678_9ABC);
    capture(48'h1234_5678_9ABC);
    chk("basic_latency_busy", 64'(busy), 64'h1);
    chk("basic_first_slice", 64'(dout), 64'h9ABC);
    tick(); tick(); tick();
    chk("basic_done_busy", 64'(busy), 64'h0);

    // Backpressure on slice 1
    push_word(48'h1234_5678_9ABC);
    capture(48'h1234_5678_9ABC);
    tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_dout", 64'(dout), 64'h5678);
      chk("bp_hold_valid", 64'(dout_valid), 64'h1);
      chk("bp_hold_last", 64'(dout_last), 64'h0);
    end
    dout_ready = 1'b1;
    tick(); tick();
    chk("bp_done_busy", 64'(busy), 64'h0);

    // Back-to-back words through the last-slice handshake
    push_word(48'h1234_5678_9ABC);
    push_word(48'hFFFF_0000_AAAA);
    capture(48'h1234_5678_9ABC);
    tick(); tick();
    chk("b2b_last_flag", 64'(dout_last), 64'h1);
    capture(48'hFFFF_0000_AAAA);
    chk("b2b_no_gap_busy", 64'(busy), 64'h1);
    chk("b2b_no_gap_dout", 64'(dout), 64'hAAAA);
    tick(); tick(); tick();
    chk("b2b_done_busy", 64'(busy), 64'h0);
    chk("b2b_no_ovr", 64'(overrun), 64'h0);

    // Overrun: drop at idx 1, then clear-vs-set, then clear alone
    push_word(48'h1234_5678_9ABC);
    capture(48'h1234_5678_9ABC);
    tick();
    capture(48'hDEAD_BEEF_0001);
    chk("ovr_set", 64'(overrun), 64'h1);
    tick();
    chk("ovr_done_busy", 64'(busy), 64'h0);
    push_word(48'h1234_5678_9ABC);
    capture(48'h1234_5678_9ABC);
    clr_ovr = 1'b1;
    capture(48'hDEAD_BEEF_0002);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'h1);
    tick(); tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'h0);

    // Clock enable low mid-word ignores ready and p_valid
    push_word(48'h1234_5678_9ABC);
    capture(48'h1234_5678_9ABC);
    tick();
    CLK_EN  = 1'b0;
    P       = 48'h0BAD_0BAD_0BAD;
    p_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ce_hold_dout", 64'(dout), 64'h5678);
      chk("ce_no_ovr", 64'(overrun), 64'h0);
    end
    CLK_EN  = 1'b1;
    p_valid = 1'b0;
    tick(); tick();
    chk("ce_done_busy", 64'(busy), 64'h0);
    chk("ce_done_ovr", 64'(overrun), 64'h0);

    // Reset while slice 1 is pending
    push_word(48'h1234_5678_9ABC);
    capture(48'h1234_5678_9ABC);
    tick();
    dout_ready = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_dout", 64'(dout), 64'h0);
    chk("mrst_valid", 64'(dout_valid), 64'h0);
    chk("mrst_last", 64'(dout_last), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_ovr", 64'(overrun), 64'h0);
    dout_ready = 1'b1;
    tick();
    chk("mrst_stays_idle", 64'(busy), 64'h0);
    push_word(48'hFFFF_0000_AAAA);
    capture(48'hFFFF_0000_AAAA);
    chk("mrst_fresh_slice0", 64'(dout), 64'hAAAA);
    tick(); tick(); tick();
    chk("final_busy", 64'(busy), 64'h0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
